// File: rtl/i2c_write_master.sv
// Byte-level I2C write engine: START, three bytes {slave, sub, data}, STOP.
// Bus timing comes from a quarter-bit tick enable on the system clock.
// The pads are open-drain, so each output is a pull-low enable.
module i2c_write_master #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oBUSY,
  output logic        oDONE,
  output logic        oACK_ERR,
  output logic        oSCL_OE,
  output logic        oSDA_OE,
  input  logic        iSDA
);

  // Clock cycles per quarter bit. The parameters must give a value of at least 1.
  localparam int QUARTER = CLK_FREQ / (4 * I2C_FREQ);
  localparam int CNT_W = $clog2(QUARTER + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUARTER - 1);

  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP} state_t;

  state_t           state, stateNext;
  logic [1:0]       quarter, quarterNext;
  logic [CNT_W-1:0] tickCnt, tickCntNext;
  logic [2:0]       bitCnt, bitCntNext;
  logic [1:0]       byteCnt, byteCntNext;
  logic [23:0]      shiftReg, shiftRegNext;
  logic             ackErr, ackErrNext;
  logic             done, doneNext;
  logic             tick;

  // State and datapath registers. A reset releases the bus on the next edge and suppresses oDONE.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state    <= IDLE;
      quarter  <= '0;
      tickCnt  <= '0;
      bitCnt   <= '0;
      byteCnt  <= '0;
      shiftReg <= '0;
      ackErr   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= stateNext;
      quarter  <= quarterNext;
      tickCnt  <= tickCntNext;
      bitCnt   <= bitCntNext;
      byteCnt  <= byteCntNext;
      shiftReg <= shiftRegNext;
      ackErr   <= ackErrNext;
      done     <= doneNext;
    end
  end

  // Next-state logic: quarter sequencing, bit and byte counting, and ACK sampling.
  always_comb begin
    stateNext    = state;
    quarterNext  = quarter;
    tickCntNext  = tickCnt;
    bitCntNext   = bitCnt;
    byteCntNext  = byteCnt;
    shiftRegNext = shiftReg;
    ackErrNext   = ackErr;
    doneNext     = 1'b0;
    tick         = 1'b0;
    if (state == IDLE) begin
      if (iGO) begin
        stateNext    = START;
        shiftRegNext = iDATA;
        ackErrNext   = 1'b0;
        bitCntNext   = '0;
        byteCntNext  = '0;
        // The accept cycle is the first cycle of START q0. In that quarter the bus
        // is released, as it is in IDLE, so this cycle already counts toward q0.
        if (CNT_MAX == '0) begin
          quarterNext = 2'd1;
          tickCntNext = '0;
        end else begin
          quarterNext = 2'd0;
          tickCntNext = CNT_W'(1);
        end
      end
    end else begin
      tick        = (tickCnt == CNT_MAX);
      tickCntNext = tick ? '0 : tickCnt + 1'b1;
      if (tick) begin
        quarterNext = quarter + 2'd1;
        // Sample the ACK on the last cycle of q1, while SCL has been high for a full quarter.
        if (state == ACK && quarter == 2'd1 && iSDA) begin
          ackErrNext = 1'b1;
        end
        if (quarter == 2'd3) begin
          case (state)
            START: stateNext = BIT;
            BIT: begin
              shiftRegNext = {shiftReg[22:0], 1'b0};
              bitCntNext   = bitCnt + 3'd1;
              if (bitCnt == 3'd7) begin
                stateNext = ACK;
              end
            end
            ACK: begin
              if (ackErr || byteCnt == 2'd2) begin
                stateNext = STOP;
              end else begin
                byteCntNext = byteCnt + 2'd1;
                stateNext   = BIT;
              end
            end
            STOP: begin
              stateNext = IDLE;
              doneNext  = 1'b1;
            end
            default: stateNext = IDLE;
          endcase
        end
      end
    end
  end

  // Bus drive, derived from the state and the current quarter. An output of 1 pulls the line low.
  always_comb begin
    oSCL_OE = 1'b0;
    oSDA_OE = 1'b0;
    case (state)
      START: begin
        oSDA_OE = (quarter != 2'd0);
        oSCL_OE = quarter[1];
      end
      BIT: begin
        oSCL_OE = (quarter == 2'd0) || (quarter == 2'd3);
        oSDA_OE = ~shiftReg[23];
      end
      ACK: begin
        oSCL_OE = (quarter == 2'd0) || (quarter == 2'd3);
        oSDA_OE = 1'b0;
      end
      STOP: begin
        oSCL_OE = (quarter == 2'd0);
        oSDA_OE = ~quarter[1];
      end
      default: begin
        oSCL_OE = 1'b0;
        oSDA_OE = 1'b0;
      end
    endcase
  end

  assign oBUSY    = (state != IDLE);
  assign oDONE    = done;
  assign oACK_ERR = ackErr;

endmodule
